// File: rtl/rom_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_load_arbiter
// Brief    : Packs SD or serial ROM bytes into 16-bit words and streams them
//            through a small FIFO to a req/ack memory write port.
// Revision : 1.0
// ============================================================================
module rom_load_arbiter #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SER_HDR     = 32,
    parameter int SER_TIMEOUT = 1_080_000
) (
    input  logic        wclk,
    input  logic        resetn,
    input  logic        sd_loading,
    input  logic [7:0]  sd_data,
    input  logic        sd_valid,
    input  logic        ser_reset,
    input  logic [7:0]  ser_data,
    input  logic        ser_valid,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        loading,
    output logic        source,
    output logic        overflow,
    output logic [23:0] bytes_written
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(SER_HDR + 2);
    localparam int TW = $clog2(SER_TIMEOUT + 1);
    localparam logic [AW:0] c_depth      = (AW + 1)'(FIFO_DEPTH);
    localparam logic [HW-1:0] c_hdr      = HW'(SER_HDR);
    localparam logic [TW-1:0] c_idle_last = TW'(SER_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SD    = 2'd1,
        ST_SER   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_sd_prev;
    logic          r_pending;
    logic [7:0]    r_lo;
    logic [HW-1:0] r_hdr_cnt;
    logic [TW-1:0] r_idle;
    logic [15:0]   r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_sd_rise;
    logic          w_hdr_done;
    logic          w_byte_valid;
    logic [7:0]    w_byte;
    logic          w_fifo_empty;
    logic          w_pop;
    logic          w_room;
    logic          w_push;
    logic [15:0]   w_push_data;
    logic          w_drop;
    logic [1:0]    w_bw_inc;
    logic [24:0]   w_bw_sum;

    assign w_sd_rise    = sd_loading & ~r_sd_prev;
    assign w_hdr_done   = (r_hdr_cnt == c_hdr);
    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = ~w_fifo_empty & (~mem_req | mem_ack);
    // A full FIFO still takes a word when a pop frees a slot in the same cycle.
    assign w_room       = (r_count != c_depth) | w_pop;
    assign w_bw_sum     = {1'b0, bytes_written} + {23'd0, w_bw_inc};

    always_comb begin
        w_byte_valid = 1'b0;
        w_byte       = sd_data;
        case (r_state)
            ST_SD: begin
                w_byte_valid = sd_valid;
                w_byte       = sd_data;
            end
            ST_SER: begin
                w_byte_valid = ser_valid & w_hdr_done;
                w_byte       = ser_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_data = {w_byte, r_lo};
        w_drop      = 1'b0;
        w_bw_inc    = 2'd0;
        if (w_byte_valid && r_pending) begin
            if (w_room) begin
                w_push   = 1'b1;
                w_bw_inc = 2'd2;
            end else begin
                w_drop = 1'b1;
            end
        end else if (r_state == ST_FLUSH && r_pending && w_room) begin
            w_push      = 1'b1;
            w_push_data = {8'hFF, r_lo};
            w_bw_inc    = 2'd1;
        end
    end

    always_ff @(posedge wclk) begin
        if (w_push) r_fifo[r_wptr] <= w_push_data;
    end

    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_sd_prev     <= 1'b1;   // a level already high at release is not an edge
            r_pending     <= 1'b0;
            r_lo          <= 8'd0;
            r_hdr_cnt     <= '0;
            r_idle        <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= 23'd0;
            mem_wdata     <= 16'd0;
            loading       <= 1'b0;
            source        <= 1'b0;
            overflow      <= 1'b0;
            bytes_written <= 24'd0;
        end else begin
            r_sd_prev <= sd_loading;

            if (w_pop) begin
                mem_req   <= 1'b1;
                mem_wdata <= r_fifo[r_rptr];
            end else if (mem_ack) begin
                mem_req <= 1'b0;
            end
            if (mem_req && mem_ack) mem_addr <= mem_addr + 23'd1;

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            if (w_drop) overflow <= 1'b1;
            bytes_written <= w_bw_sum[24] ? 24'hFFFFFF : w_bw_sum[23:0];

            if (w_byte_valid) begin
                r_lo      <= w_byte;
                r_pending <= ~r_pending;
            end else if (w_push) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_sd_rise || ser_reset) begin
                        r_state       <= w_sd_rise ? ST_SD : ST_SER;
                        source        <= ~w_sd_rise;
                        loading       <= 1'b1;
                        mem_addr      <= 23'd0;
                        bytes_written <= 24'd0;
                        overflow      <= 1'b0;
                        r_pending     <= 1'b0;
                        r_hdr_cnt     <= '0;
                        r_idle        <= '0;
                    end
                end
                ST_SD: begin
                    if (!sd_loading && r_sd_prev) r_state <= ST_FLUSH;
                end
                ST_SER: begin
                    if (ser_valid) begin
                        r_idle <= '0;
                        if (!w_hdr_done) r_hdr_cnt <= r_hdr_cnt + 1'b1;
                    end else if (r_idle == c_idle_last) begin
                        r_state <= ST_FLUSH;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (w_fifo_empty && !mem_req && !r_pending) begin
                        r_state <= ST_IDLE;
                        loading <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rom_load_arbiter.md
ROM_LOAD_ARBITER -- requirements
Module: rom_load_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, the word FIFO depth (power of 2, at least 2).
REQ-002 SHALL have parameter SER_HDR, default 32, the number of leading serial-session bytes not written to memory.
REQ-003 SHALL have parameter SER_TIMEOUT, default 1_080_000, the idle cycles with no ser_valid that end a serial session.
REQ-004 wclk  in  1  sole clock; all logic on the rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 sd_loading  in  1  SD-loader session level.
REQ-007 sd_data  in  8  SD ROM byte.
REQ-008 sd_valid  in  1  sd_data strobe, one byte per cycle.
REQ-009 ser_reset  in  1  pulse that starts a serial session.
REQ-010 ser_data  in  8  serial byte.
REQ-011 ser_valid  in  1  ser_data strobe.
REQ-012 mem_req  out  1  memory write request.
REQ-013 mem_ack  in  1  memory write accept.
REQ-014 mem_addr  out  23  word address.
REQ-015 mem_wdata  out  16  write word.
REQ-016 loading  out  1  session active, including drain.
REQ-017 source  out  1  current or last session source: 0 = SD, 1 = serial.
REQ-018 overflow  out  1  sticky flag: a byte was dropped.
REQ-019 bytes_written  out  24  count of bytes accepted into memory words.

Function
REQ-020 SHALL implement the states IDLE, SD, SER and FLUSH.
REQ-021 IDLE->SD on a rising edge of sd_loading; IDLE->SER on ser_reset; if both occur in the same cycle, SD wins and ser_reset is dropped.
REQ-022 On any session start, SHALL clear the word address, bytes_written, overflow, the pending-byte flag and the header counter; SHALL set source.
REQ-023 In SD, SHALL accept only sd_valid bytes; ser_reset and ser_valid are ignored.
REQ-024 In SER, SHALL accept only ser_valid bytes; sd_loading edges are ignored.
REQ-025 In SER, the first SER_HDR bytes SHALL be discarded without being counted.
REQ-026 SD->FLUSH on the sd_loading falling edge; a byte valid in that same cycle is still accepted.
REQ-027 SER->FLUSH when SER_TIMEOUT consecutive cycles pass with no ser_valid.
REQ-028 The timeout counter SHALL reload on every ser_valid; a ser_reset pulse inside SER is ignored.
REQ-029 Packing is little-endian: the first byte of a pair goes to wdata[7:0], the second to wdata[15:8].
REQ-030 The completed word SHALL be pushed into the FIFO at the edge that ends the second byte's valid cycle.
REQ-031 In FLUSH, a pending odd byte SHALL be pushed once, with the high byte 8'hFF.
REQ-032 FLUSH->IDLE when the FIFO is empty and no request is outstanding; loading SHALL fall in the cycle IDLE is entered.
REQ-033 loading SHALL be high from the cycle after session start through the last FLUSH cycle.
REQ-034 mem_req/mem_addr/mem_wdata SHALL come from an output register.
REQ-035 mem_req SHALL stay high, with mem_addr and mem_wdata stable, until sampled with mem_ack high.
REQ-036 After an accepting mem_ack, the next word SHALL be presented in the next cycle if available, so back-to-back acks give one word per cycle.
REQ-037 mem_ack while mem_req is low SHALL be ignored.
REQ-038 mem_addr SHALL start at 0 and increment by 1 per accepted word, wrapping at 2^23.
REQ-039 With an empty FIFO and an idle output register, mem_req SHALL rise exactly 2 cycles after the valid cycle of the pair's second byte.
REQ-040 If a pair completes while the FIFO is full, the word SHALL be dropped and overflow set until the next session start; a dropped word's bytes are not counted.
REQ-041 A push and a pop in the same cycle on a full FIFO SHALL both occur, with no overflow.
REQ-042 bytes_written SHALL increment by 2 per pushed pair and by 1 for the flushed odd byte, saturating at 24'hFFFFFF.

Reset
REQ-043 Asserting resetn low SHALL, asynchronously and in any state, set state=IDLE, mem_req=0, mem_addr=0, mem_wdata=0, loading=0, source=0, overflow=0, bytes_written=0, and empty the FIFO.
REQ-044 Reset mid-session SHALL abandon all buffered data.
REQ-045 After release, SHALL wait for a new session start and SHALL NOT treat an sd_loading already high as a rising edge.

Verification
REQ-046 SD session, bytes 11,22,33,44, mem_ack tied high -> writes (0,16'h2211), (1,16'h4433); bytes_written=4; loading falls after drain.
REQ-047 Serial: ser_reset, 35 bytes 00..22h, then idle SER_TIMEOUT cycles -> header 00..1Fh skipped; writes (0,16'h2120), (1,16'hFF22); bytes_written=3.
REQ-048 mem_ack held low for 100 cycles with 20 SD bytes, FIFO_DEPTH=8 -> mem_req stays high with a stable word, overflow=1, bytes_written=18, and the dropped-word bytes are absent.
REQ-049 sd_loading rise and ser_reset in the same cycle -> source=0, serial bytes ignored.
REQ-050 resetn pulsed low mid-SD with a pending request -> mem_req=0 immediately; no writes until a new sd_loading rising edge.
